// File: rtl/mmio_port_responder_pkg.sv
// Shared definitions for the memory-mapped output/input port block:
// register offsets, STATUS bit positions and the default base address.
package mmio_port_responder_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0100;

  typedef enum logic [1:0] {
    REG_OUT_DATA = 2'd0,
    REG_STATUS   = 2'd1,
    REG_IN_DATA  = 2'd2,
    REG_RSVD     = 2'd3
  } reg_off_e;

  localparam int STAT_FULL       = 0;
  localparam int STAT_EMPTY      = 1;
  localparam int STAT_IN_CHANGED = 2;
  localparam int STAT_OVERFLOW   = 3;
  localparam int STAT_COUNT_LSB  = 4;
  localparam int STAT_COUNT_W    = 5;

  // The block decodes a 16-byte window; only the upper 28 address bits matter.
  function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base);
    return (addr[31:4] == base[31:4]);
  endfunction

endpackage

// File: rtl/mmio_port_responder_sync_fifo.sv
// Single-clock FIFO with push/pop handshake; a push while full is accepted
// only when a pop frees the head slot on the same edge.
module sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_count == CW'(0));
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  // Empty FIFO presents zero so the sink never sees stale storage.
  assign rdata     = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset && w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_port_responder.sv
// Memory-mapped port block: stores to OUT_DATA feed an output FIFO, PortIn is
// synchronized with change detection, STATUS reports FIFO and sticky flags.
module mmio_port_responder
  import mmio_port_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Hit,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic        PortOutValid,
  input  logic        PortOutReady
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]  r_sync1, r_sync2, r_in_prev;
  logic        r_in_changed, r_overflow;
  logic [31:0] r_last_out;

  logic          w_full, w_empty, w_pop, w_push;
  logic [CW-1:0] w_count;
  logic          w_store, w_load, w_out_store, w_ovf_evt, w_in_chg_evt;
  reg_off_e      w_off;
  logic [31:0]   w_status;

  assign Hit          = addr_hit(Address, BASE_ADDR);
  assign w_off        = reg_off_e'(Address[3:2]);
  assign w_store      = MemWrite && Hit;
  // A simultaneous load and store behaves as a store with no read side effects.
  assign w_load       = MemRead && !MemWrite && Hit;
  assign PortOutValid = !w_empty;
  assign w_pop        = PortOutValid && PortOutReady;
  assign w_out_store  = w_store && (w_off == REG_OUT_DATA);
  assign w_push       = w_out_store && (!w_full || w_pop);
  assign w_ovf_evt    = w_out_store && w_full && !w_pop;
  assign w_in_chg_evt = (r_sync2 != r_in_prev);

  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_out_store),
    .pop   (w_pop),
    .wdata (WriteData),
    .rdata (PortOut),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_comb begin
    w_status                                          = '0;
    w_status[STAT_FULL]                               = w_full;
    w_status[STAT_EMPTY]                              = w_empty;
    w_status[STAT_IN_CHANGED]                         = r_in_changed;
    w_status[STAT_OVERFLOW]                           = r_overflow;
    w_status[STAT_COUNT_LSB +: STAT_COUNT_W]          = STAT_COUNT_W'(w_count);
  end

  always_comb begin
    ReadData = '0;
    if (w_load) begin
      case (w_off)
        REG_OUT_DATA: ReadData = r_last_out;
        REG_STATUS:   ReadData = w_status;
        REG_IN_DATA:  ReadData = {24'h00_0000, r_sync2};
        default:      ReadData = '0;
      endcase
    end else begin
      ReadData = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_in_prev    <= '0;
      r_in_changed <= 1'b0;
      r_overflow   <= 1'b0;
      r_last_out   <= '0;
    end else begin
      r_sync1   <= PortIn;
      r_sync2   <= r_sync1;
      r_in_prev <= r_sync2;
      // Set events win over read-to-clear on the same edge.
      if (w_in_chg_evt)                        r_in_changed <= 1'b1;
      else if (w_load && w_off == REG_IN_DATA) r_in_changed <= 1'b0;
      if (w_ovf_evt)                           r_overflow <= 1'b1;
      else if (w_load && w_off == REG_STATUS)  r_overflow <= 1'b0;
      if (w_push)                              r_last_out <= WriteData;
    end
  end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed bench: expected load data and expected sink words are queued by
// the stimulus and consumed by a negedge monitor.
module tb_mmio_port_responder;

  localparam logic [31:0] BASE = 32'h1001_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] ReadData;
  logic        Hit;
  logic [7:0]  PortIn = '0;
  logic [31:0] PortOut;
  logic        PortOutValid;
  logic        PortOutReady = 1'b0;

  int n_vec = 0;
  int n_miss = 0;
  logic [31:0] exp_rd_q[$];
  logic [31:0] exp_out_q[$];

  mmio_port_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .Address      (Address),
    .WriteData    (WriteData),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .ReadData     (ReadData),
    .Hit          (Hit),
    .PortIn       (PortIn),
    .PortOut      (PortOut),
    .PortOutValid (PortOutValid),
    .PortOutReady (PortOutReady)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    Address = a; WriteData = d; MemWrite = 1'b1;
    cyc();
    MemWrite = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] exp);
    exp_rd_q.push_back(exp);
    Address = a; MemRead = 1'b1;
    cyc();
    MemRead = 1'b0;
  endtask

  task automatic drain(input logic [31:0] v);
    exp_out_q.push_back(v);
    PortOutReady = 1'b1;
    cyc();
    PortOutReady = 1'b0;
  endtask

  // Monitor: consume one expectation per load and per sink handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (MemRead) begin
        if (exp_rd_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL unexpected_load: got 0x%08h expected none", ReadData);
        end else begin
          chk("ReadData", ReadData, exp_rd_q.pop_front());
        end
      end
      if (PortOutValid && PortOutReady) begin
        if (exp_out_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL unexpected_pop: got 0x%08h expected none", PortOut);
        end else begin
          chk("PortOut", PortOut, exp_out_q.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (2) cyc();
    reset = 1'b0;

    // Reset state
    chk("reset_valid", 32'(PortOutValid), 32'h0);
    chk("reset_portout", PortOut, 32'h0);
    load(BASE + 32'h4, 32'h0000_0002);
    load(BASE + 32'h0, 32'h0000_0000);
    load(BASE + 32'h8, 32'h0000_0000);

    // Single store, one-cycle latency, single pop
    store(BASE, 32'hDEAD_BEEF);
    chk("valid_after_store", 32'(PortOutValid), 32'h1);
    chk("head_after_store", PortOut, 32'hDEAD_BEEF);
    drain(32'hDEAD_BEEF);
    chk("valid_after_pop", 32'(PortOutValid), 32'h0);
    load(BASE + 32'h4, 32'h0000_0002);

    // Overflow: fifth store dropped, sticky cleared by STATUS read
    for (int i = 1; i <= 5; i++) store(BASE + 32'h3, 32'(i));
    load(BASE + 32'h4, 32'h0000_0049);
    load(BASE + 32'h4, 32'h0000_0041);
    load(BASE, 32'h0000_0004);
    for (int i = 1; i <= 4; i++) drain(32'(i));
    load(BASE + 32'h4, 32'h0000_0002);

    // Push while full with same-edge pop
    for (int i = 10; i <= 13; i++) store(BASE, 32'(i));
    exp_out_q.push_back(32'd10);
    PortOutReady = 1'b1;
    store(BASE, 32'd9);
    PortOutReady = 1'b0;
    load(BASE + 32'h4, 32'h0000_0041);
    drain(32'd11); drain(32'd12); drain(32'd13); drain(32'd9);
    load(BASE + 32'h4, 32'h0000_0002);

    // PortIn change detection through the synchronizer
    PortIn = 8'hA5;
    cyc();
    cyc();
    load(BASE + 32'h4, 32'h0000_0002);
    load(BASE + 32'h4, 32'h0000_0006);
    load(BASE + 32'h8, 32'h0000_00A5);
    load(BASE + 32'h4, 32'h0000_0002);

    // Out-of-window access and ignored stores
    Address = BASE + 32'h10;
    #1 chk("hit_outside", 32'(Hit), 32'h0);
    load(BASE + 32'h10, 32'h0);
    store(BASE + 32'h10, 32'h1234_5678);
    store(BASE + 32'h4, 32'h1234_5678);
    store(BASE + 32'hC, 32'h1234_5678);
    Address = BASE + 32'hF;
    #1 chk("hit_top_byte", 32'(Hit), 32'h1);
    load(BASE + 32'hC, 32'h0);
    load(BASE + 32'h4, 32'h0000_0002);

    // Reset with entries queued and a store in flight
    for (int i = 0; i < 3; i++) store(BASE, 32'h100 + 32'(i));
    reset = 1'b1;
    store(BASE, 32'h0000_0777);
    reset = 1'b0;
    chk("valid_after_reset", 32'(PortOutValid), 32'h0);
    load(BASE + 32'h4, 32'h0000_0002);
    load(BASE, 32'h0000_0000);

    cyc();
    chk("rd_queue_empty", 32'(exp_rd_q.size()), 32'h0);
    chk("out_queue_empty", 32'(exp_out_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
